// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
//   Request/acknowledge bus between the MEM pipeline stage and the data memory.
//   Signal names carry the stage's point of view (_o driven by the stage,
//   _i driven by the memory).
//   mem_req_o   : request, held until acknowledged
//   mem_we_o    : 1 = write, 0 = read
//   mem_addr_o  : word-aligned byte address
//   mem_wdata_o : store data
//   mem_ack_i   : access complete; mem_rdata_i valid this cycle for reads
//   mem_rdata_i : load data
//   modport master : pipeline stage side
//   modport slave  : memory side
interface mem_access_stage_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-access stage of the 5-stage pipeline. Turns a MEM-stage load/store
//   into a req/ack transaction with a variable-latency data memory, stalls the
//   upstream pipeline until it completes, and presents write-back control,
//   load data, ALU result and destination register to MEM/WB. Misaligned and
//   timed-out accesses are squashed into bubbles and raise a sticky error.
//
//   Parameter TIMEOUT : max REQ cycles waiting for an ack (>= 2)
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   valid_i, M_i      : valid instruction, {MemRead, MemWrite}
//   WB_i, addr_i      : write-back control, ALU result / byte address
//   wdata_i, RDaddr_i : store data, destination register
//   mem               : data-memory bus (master side)
//   stall_o           : freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//   WB_o, data1_o     : write-back control (0 = bubble), load data
//   data2_o, RDaddr_o : ALU result, destination register
//   err_o             : sticky misaligned/timeout error
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic [1:0]                 M_i,
  input  logic [1:0]                 WB_i,
  input  logic [31:0]                addr_i,
  input  logic [31:0]                wdata_i,
  input  logic [4:0]                 RDaddr_i,
  mem_access_stage_if.master         mem,
  output logic                       stall_o,
  output logic [1:0]                 WB_o,
  output logic [31:0]                data1_o,
  output logic [31:0]                data2_o,
  output logic [4:0]                 RDaddr_o,
  output logic                       err_o
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          abort_q, abort_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q,   err_d;
  logic [31:2]   addr_q,  addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q,    we_d;

  logic access;
  logic misaligned;

  // MemWrite wins when both control bits are set, so we is simply M_i[0].
  assign access     = valid_i & (M_i[1] | M_i[0]);
  assign misaligned = access & (addr_i[1:0] != 2'b00);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      abort_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      abort_q <= abort_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    abort_d         = abort_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    we_d            = we_q;

    stall_o         = 1'b0;
    WB_o            = '0;
    data1_o         = '0;
    data2_o         = addr_i;
    RDaddr_o        = RDaddr_i;
    mem.mem_req_o   = 1'b0;
    mem.mem_we_o    = 1'b0;
    mem.mem_addr_o  = '0;
    mem.mem_wdata_o = '0;

    unique case (state_q)
      S_IDLE: begin
        stall_o = access;
        if (!access) begin
          WB_o = WB_i;
        end else if (misaligned) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_i[31:2];
          wdata_d = wdata_i;
          we_d    = M_i[0];
          count_d = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        stall_o         = 1'b1;
        mem.mem_req_o   = 1'b1;
        mem.mem_we_o    = we_q;
        mem.mem_addr_o  = {addr_q, 2'b00};
        mem.mem_wdata_o = wdata_q;
        // An ack in the final counted cycle takes priority over the timeout.
        if (mem.mem_ack_i) begin
          rdata_d = we_q ? '0 : mem.mem_rdata_i;
          abort_d = 1'b0;
          state_d = S_DONE;
        end else if (count_q == CNT_LAST) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end

      S_DONE: begin
        if (!abort_q) begin
          WB_o    = WB_i;
          data1_o = rdata_q;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign err_o = err_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 5-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register. It turns the MEM-stage load/store request into a req/ack transaction with a variable-latency data memory, and stalls the upstream pipeline until the access completes. It presents MEM/WB with write-back control, load data, ALU result and destination register. Failed accesses (misaligned or timed-out) are squashed into bubbles and flagged.

## Interface
- TIMEOUT, 16: maximum REQ-state cycles to wait for mem_ack_i before aborting (≥2).
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  MEM stage holds a valid instruction.
- M_i  in  2  {MemRead, MemWrite} from EX/MEM.
- WB_i  in  2  write-back control from EX/MEM.
- addr_i  in  32  ALU result / memory byte address.
- wdata_i  in  32  store data.
- RDaddr_i  in  5  destination register.
- mem_req_o  out  1  memory request, held until ack.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  32  word-aligned byte address.
- mem_wdata_o  out  32  store data.
- mem_ack_i  in  1  access complete; mem_rdata_i valid this cycle for reads.
- mem_rdata_i  in  32  load data.
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
- WB_o  out  2  write-back control to MEM/WB (0 = bubble).
- data1_o  out  32  load data to MEM/WB.
- data2_o  out  32  ALU result to MEM/WB (= addr_i).
- RDaddr_o  out  5  destination register to MEM/WB.
- err_o  out  1  sticky error: misaligned access or timeout.

## Operation
- Access = valid_i & (M_i[1] | M_i[0]). If both bits are set, the access is a write (MemWrite wins).
- Misaligned = access & (addr_i[1:0] != 0). No request is issued. The stage goes to DONE with the abort flag set and sets err_o. There is no stall beyond the IDLE cycle.
- States:
  - IDLE: if an aligned access is present, latch addr_i, wdata_i and we, clear the timeout counter, go to REQ. If misaligned, go to DONE with abort=1. Otherwise stay in IDLE.
  - REQ: mem_req_o=1, and mem_addr_o, mem_wdata_o, mem_we_o come from the latches. On mem_ack_i: capture mem_rdata_i into rdata_q (only for reads; otherwise rdata_q=0), set abort=0, go to DONE. Without ack: count+1. If count == TIMEOUT-1, set abort=1 and err_o=1, and go to DONE.
  - DONE: always go to IDLE on the next edge.
- stall_o = (IDLE & access) | REQ. It is 0 in DONE.
- Outputs toward MEM/WB (combinational from state and inputs):
  - IDLE, no access: WB_o=WB_i, data1_o=0, data2_o=addr_i, RDaddr_o=RDaddr_i; the instruction passes with no stall.
  - IDLE with access, or REQ: WB_o=0, so MEM/WB captures a bubble.
  - DONE, abort=0: WB_o=WB_i, data1_o=rdata_q, data2_o=addr_i, RDaddr_o=RDaddr_i.
  - DONE, abort=1: WB_o=0, data1_o=0.
- Inputs are stable throughout IDLE→REQ→DONE because stall_o holds EX/MEM. EX/MEM advances at the end of DONE.
- mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are 0 outside REQ.
- err_o stays set until rst_i.

## Timing
- Reset values: state=IDLE, count=0, abort=0, rdata_q=0, err_o=0, mem_req_o=0. Combinational outputs follow IDLE rules.
- Reset asserted mid-REQ drops mem_req_o immediately. A late mem_ack_i arriving in IDLE or DONE is ignored.
- Non-memory instruction: 0 stall cycles; MEM/WB captures it at the end of the same cycle.
- Aligned access with ack in the first REQ cycle: cycle 0 IDLE (stall), cycle 1 REQ (stall, ack), cycle 2 DONE (no stall). MEM/WB captures at the end of cycle 2.
- Ack after k REQ cycles (k ≥ 1): total stall cycles = k+1.
- Timeout: exactly TIMEOUT REQ cycles, then DONE with bubble. An ack arriving in the same cycle as count==TIMEOUT-1 wins: the access is normal, not aborted.
- mem_ack_i is only sampled in REQ.
- Back-to-back accesses: DONE→IDLE, then a new access re-enters REQ. There is at least 1 IDLE cycle between requests.

## Test plan
- Reset, then ALU op with WB_i=2'b10, addr_i=0x1234, RDaddr_i=5 → stall_o=0, WB_o=2'b10, data2_o=0x1234, RDaddr_o=5 in the same cycle.
- Load addr 0x40, ack on the first REQ cycle with rdata 0xDEADBEEF → stall_o high for 2 cycles, mem_addr_o=0x40, mem_we_o=0. In DONE: data1_o=0xDEADBEEF, WB_o=WB_i.
- Store addr 0x80, data 0x55AA, ack after 5 REQ cycles → mem_we_o=1, mem_wdata_o=0x55AA held for all 5 cycles, stall for 6 cycles, data1_o=0 in DONE.
- Load addr 0x42 → no mem_req_o, err_o=1, WB_o=0 in DONE, stall for 1 cycle.
- Load with no ack, TIMEOUT=16 → mem_req_o high for exactly 16 cycles, then DONE with WB_o=0 and err_o=1. A second case with ack on the 16th REQ cycle completes normally with err_o=0.
- rst_i asserted during REQ, with ack arriving 2 cycles later → mem_req_o=0 immediately, state IDLE, ack ignored, err_o=0.
